// File: rtl/utm_tape_sequencer.sv
// Turing-machine tape sequencer: fetches the symbol under the head,
// hands it to an external transition core and commits the result.
module utm_tape_sequencer #(
  parameter int         TAPE_DEPTH = 16,
  parameter logic [2:0] HALT_STATE = 3'b111,
  parameter logic [7:0] MAX_STEPS  = 8'd255,
  localparam int        AW         = $clog2(TAPE_DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          tape_wr_en,
  input  logic [AW-1:0] tape_wr_addr,
  input  logic [2:0]    tape_wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [2:0]    rd_data,
  output logic          core_reset,
  output logic [2:0]    core_sym,
  output logic          core_sym_valid,
  input  logic [2:0]    core_new_sym,
  input  logic          core_direction,
  input  logic [2:0]    core_next_state,
  output logic [AW-1:0] head,
  output logic [7:0]    step_count,
  output logic          busy,
  output logic          done,
  output logic          halted,
  output logic          timeout
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    COMMIT,
    DONE
  } state_t;

  localparam logic [AW-1:0] ONE = 1;

  state_t      state, state_n;
  logic [2:0]  tape [TAPE_DEPTH];
  logic [2:0]  cap_sym;
  logic        cap_dir;
  logic [2:0]  cap_state;
  logic [7:0]  step_inc;
  logic        go;
  logic        hit_halt;
  logic        hit_limit;

  assign step_inc  = step_count + 8'd1;
  assign hit_halt  = cap_state == HALT_STATE;
  assign hit_limit = step_inc == MAX_STEPS;
  assign go        = start && !busy;

  always_comb begin
    state_n        = state;
    busy           = 1'b0;
    done           = 1'b0;
    core_sym_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = FETCH;
      end
      FETCH: begin
        busy           = 1'b1;
        core_sym_valid = 1'b1;
        state_n        = EXEC;
      end
      EXEC: begin
        busy    = 1'b1;
        state_n = COMMIT;
      end
      COMMIT: begin
        busy = 1'b1;
        if (hit_halt || hit_limit) state_n = DONE;
        else                       state_n = FETCH;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
  end

  assign core_reset = !busy;
  assign core_sym   = tape[head];
  assign rd_data    = tape[rd_addr];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= '0;
      step_count <= '0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      cap_sym    <= '0;
      cap_dir    <= 1'b0;
      cap_state  <= '0;
    end else if (go) begin
      head       <= '0;
      step_count <= '0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
    end else if (state == EXEC) begin
      cap_sym   <= core_new_sym;
      cap_dir   <= core_direction;
      cap_state <= core_next_state;
    end else if (state == COMMIT) begin
      head       <= cap_dir ? head + ONE : head - ONE;
      step_count <= step_inc;
      // halt wins when both end conditions land on the same step
      halted     <= hit_halt;
      timeout    <= !hit_halt && hit_limit;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < TAPE_DEPTH; i++) tape[i] <= '0;
    end else if (state == COMMIT) begin
      tape[head] <= cap_sym;
    end else if (!busy && tape_wr_en) begin
      tape[tape_wr_addr] <= tape_wr_data;
    end
  end

endmodule

// File: tb/tb_utm_tape_sequencer.sv
// Bench for utm_tape_sequencer: tape/run model checked every cycle
// plus directed literal checks on single step, wrap, timeout, lockout.
module tb_utm_tape_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       tape_wr_en = 1'b0;
  logic [3:0] tape_wr_addr = '0;
  logic [2:0] tape_wr_data = '0;
  logic [3:0] rd_addr = '0;
  logic [2:0] rd_data;
  logic       core_reset;
  logic [2:0] core_sym;
  logic       core_sym_valid;
  logic [2:0] core_new_sym = '0;
  logic       core_direction = 1'b0;
  logic [2:0] core_next_state = '0;
  logic [3:0] head;
  logic [7:0] step_count;
  logic       busy, done, halted, timeout;

  int errors = 0;
  int checks = 0;

  utm_tape_sequencer dut (
    .clock(clock), .reset(reset), .start(start),
    .tape_wr_en(tape_wr_en), .tape_wr_addr(tape_wr_addr),
    .tape_wr_data(tape_wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .core_reset(core_reset), .core_sym(core_sym),
    .core_sym_valid(core_sym_valid), .core_new_sym(core_new_sym),
    .core_direction(core_direction), .core_next_state(core_next_state),
    .head(head), .step_count(step_count), .busy(busy), .done(done),
    .halted(halted), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Reference: a tape array, head position, step tally and the
  // cycle index (0..2) inside the current step of an active run.
  logic [2:0] m_tape [16];
  int         m_head, m_steps, m_phase;
  bit         m_run, m_done, m_halt, m_tout;
  logic [2:0] m_sym, m_nst;
  bit         m_dir;

  bit         fixed_core = 1'b0;
  logic [2:0] fix_sym = '0, fix_state = '0;
  bit         fix_dir = 1'b0;
  int         halt_pct = 20;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      foreach (m_tape[i]) m_tape[i] = '0;
      m_run = 0; m_done = 0; m_halt = 0; m_tout = 0;
      m_head = 0; m_steps = 0; m_phase = 0;
    end else if (!m_run) begin
      if (tape_wr_en) m_tape[tape_wr_addr] = tape_wr_data;
      if (start) begin
        m_run = 1; m_done = 0; m_halt = 0; m_tout = 0;
        m_head = 0; m_steps = 0; m_phase = 0;
      end
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_sym = core_new_sym;
      m_dir = core_direction;
      m_nst = core_next_state;
      m_phase = 2;
    end else begin
      m_tape[m_head] = m_sym;
      m_head = (m_head + (m_dir ? 1 : 15)) % 16;
      m_steps++;
      m_phase = 0;
      if (m_nst == 3'b111) begin
        m_halt = 1; m_run = 0; m_done = 1;
      end else if (m_steps == 255) begin
        m_tout = 1; m_run = 0; m_done = 1;
      end
    end
  endtask

  task automatic compare();
    bit sv;
    sv = m_run && m_phase == 0;
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("core_reset", core_reset, !m_run);
    chk("core_sym_valid", core_sym_valid, sv);
    if (sv) chk("core_sym", core_sym, m_tape[m_head]);
    chk("head", head, m_head);
    chk("step_count", step_count, m_steps);
    chk("halted", halted, m_halt);
    chk("timeout", timeout, m_tout);
    chk("rd_data", rd_data, m_tape[rd_addr]);
  endtask

  // Registered core: results appear the cycle after core_sym_valid;
  // in every other cycle its outputs are junk.
  task automatic tick();
    bit was_fetch;
    was_fetch = m_run && m_phase == 0 && !reset;
    model_step();
    @(posedge clock);
    #1;
    if (was_fetch && fixed_core) begin
      core_new_sym    = fix_sym;
      core_direction  = fix_dir;
      core_next_state = fix_state;
    end else if (was_fetch) begin
      core_new_sym    = 3'($urandom_range(7));
      core_direction  = 1'($urandom_range(1));
      core_next_state = ($urandom_range(99) < halt_pct) ?
                        3'b111 : 3'($urandom_range(6));
    end else begin
      core_new_sym    = 3'($urandom_range(7));
      core_direction  = 1'($urandom_range(1));
      core_next_state = 3'($urandom_range(7));
    end
    compare();
  endtask

  task automatic cycle(bit st, bit we, logic [3:0] wa,
                       logic [2:0] wd, bit rst);
    start        = st;
    tape_wr_en   = we;
    tape_wr_addr = wa;
    tape_wr_data = wd;
    reset        = rst;
    rd_addr      = 4'($urandom_range(15));
    tick();
    start      = 1'b0;
    tape_wr_en = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic set_core(logic [2:0] s, bit d, logic [2:0] q);
    fixed_core = 1'b1;
    fix_sym = s; fix_dir = d; fix_state = q;
  endtask

  task automatic peek(logic [3:0] a, logic [2:0] exp, string name);
    rd_addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask

  initial begin
    int n;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    for (int a = 0; a < 16; a++) peek(4'(a), 3'd0, "rst_tape");

    // single step ending in halt
    cycle(0, 1, 4'd0, 3'd2, 0);
    set_core(3'd5, 1'b1, 3'b111);
    cycle(1, 0, 0, 0, 0);
    chk("s1_sym", core_sym, 2);
    idle(3);
    chk("s1_done", done, 1);
    chk("s1_halted", halted, 1);
    chk("s1_head", head, 1);
    chk("s1_steps", step_count, 1);
    peek(4'd0, 3'd5, "s1_tape0");

    // write and start together from DONE
    set_core(3'd1, 1'b1, 3'b111);
    cycle(1, 1, 4'd0, 3'd4, 0);
    chk("ws_sym", core_sym, 4);
    chk("ws_valid", core_sym_valid, 1);
    chk("ws_steps", step_count, 0);
    chk("ws_halted", halted, 0);
    idle(3);

    // leftward wrap, then lockout, then reset in EXEC
    set_core(3'd2, 1'b0, 3'd1);
    cycle(1, 0, 0, 0, 0);
    idle(3);
    chk("wrap_h1", head, 15);
    idle(3);
    chk("wrap_h2", head, 14);
    cycle(1, 1, 4'd3, 3'd7, 0);
    chk("lock_steps", step_count, 2);
    chk("lock_busy", busy, 1);
    peek(4'd3, 3'd0, "lock_tape3");
    cycle(0, 0, 0, 0, 1);
    chk("rx_busy", busy, 0);
    chk("rx_core_reset", core_reset, 1);
    chk("rx_head", head, 0);
    for (int a = 0; a < 16; a++) peek(4'(a), 3'd0, "rx_tape");

    // step budget exhausted
    set_core(3'd1, 1'b1, 3'd0);
    cycle(1, 0, 0, 0, 0);
    n = 0;
    while (!done && n < 1000) begin
      idle(1);
      n++;
    end
    chk("to_cycles", n + 1, 766);
    chk("to_timeout", timeout, 1);
    chk("to_halted", halted, 0);
    chk("to_steps", step_count, 255);

    // halt on the very step that hits the budget
    cycle(1, 0, 0, 0, 0);
    idle(762);
    fix_state = 3'b111;
    idle(3);
    chk("hl_halted", halted, 1);
    chk("hl_timeout", timeout, 0);
    chk("hl_steps", step_count, 255);

    // randomized traffic
    fixed_core = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(9) == 0, $urandom_range(9) < 3,
            4'($urandom_range(15)), 3'($urandom_range(7)),
            $urandom_range(199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/utm_tape_sequencer.md
UTM_TAPE_SEQUENCER -- requirements
Module: utm_tape_sequencer

Interface
REQ-001 Parameters: TAPE_DEPTH 16 (tape cells; index width 4); HALT_STATE 3'b111 (encoded state that halts a run); MAX_STEPS 8'd255 (step budget per run).
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to begin a run; honoured only when not busy.
REQ-005 tape_wr_en / tape_wr_addr / tape_wr_data  in  1/4/3  tape preload port; honoured only when not busy.
REQ-006 rd_addr  in  4; rd_data  out  3  combinational tape readback, rd_data = tape[rd_addr].
REQ-007 core_reset  out  1  reset to the transition core; forces the core to encoded state 0.
REQ-008 core_sym  out  3; core_sym_valid  out  1  symbol under the head presented to the core.
REQ-009 core_new_sym  in  3; core_direction  in  1 (1 = right, 0 = left); core_next_state  in  3  core results, registered by the core, valid the cycle after core_sym_valid.
REQ-010 head  out  4; step_count  out  8; busy  out  1; done  out  1; halted  out  1; timeout  out  1.

Function
REQ-011 The FSM SHALL have states IDLE, FETCH, EXEC, COMMIT, DONE; busy = 1 in FETCH, EXEC and COMMIT.
REQ-012 IDLE or DONE with start = 1 SHALL go to FETCH next cycle, clearing head, step_count, halted and timeout to 0.
REQ-013 core_reset SHALL be 1 in IDLE and DONE and 0 in FETCH, EXEC and COMMIT.
REQ-014 FETCH SHALL drive core_sym = tape[head] and core_sym_valid = 1, then go to EXEC; core_sym_valid SHALL be 0 in every other state.
REQ-015 EXEC SHALL capture core_new_sym, core_direction and core_next_state into holding registers, then go to COMMIT.
REQ-016 COMMIT SHALL write tape[head] = captured new_sym, update head by +1 (right) or -1 (left) modulo 16, and increment step_count.
REQ-017 Head SHALL wrap: 15 moving right becomes 0; 0 moving left becomes 15.
REQ-018 In COMMIT, captured next_state == HALT_STATE SHALL set halted = 1 and go to DONE.
REQ-019 Otherwise in COMMIT, a post-increment step_count == MAX_STEPS SHALL set timeout = 1 and go to DONE.
REQ-020 Otherwise COMMIT SHALL return to FETCH; one step therefore takes exactly 3 cycles.
REQ-021 If halt and step limit occur in the same COMMIT, halted = 1 and timeout = 0 (halt has priority).
REQ-022 done SHALL be 1 exactly while in DONE; halted, timeout, head, step_count and tape SHALL hold there until the next start or reset.
REQ-023 start, tape_wr_en or both asserted while busy SHALL be ignored with no side effect.
REQ-024 tape_wr_en in IDLE or DONE SHALL write tape[tape_wr_addr] = tape_wr_data at the edge.
REQ-025 start together with tape_wr_en in the same cycle SHALL perform the write and start the run; the first FETCH SHALL see the written value.
REQ-026 rd_data SHALL reflect the tape in every state, including mid-run.

Reset
REQ-027 reset SHALL have priority over all inputs, in every state including mid-run.
REQ-028 On reset: state = IDLE; every tape cell = 0; head, step_count, halted, timeout, done, busy and core_sym_valid = 0; core_reset = 1.
REQ-029 A run interrupted by reset SHALL NOT complete its pending tape write.

Verification
REQ-030 Single step: preload tape[0] = 3'd2; start; core model returns (new_sym = 5, dir = 1, next_state = HALT) -> at 3 cycles after start, tape[0] = 5, head = 1, step_count = 1, halted = 1, done = 1.
REQ-031 Wrap: run from head 0 with core returning dir = 0 and a non-halt state -> head = 15 after step 1 and 14 after step 2.
REQ-032 Timeout: core never returns HALT -> done = 1 with timeout = 1 and step_count = 255 exactly 765 cycles after start.
REQ-033 Busy lockout: during a run, assert start and tape_wr_en(addr 3, data 7) -> tape[3] unchanged and the run is not restarted.
REQ-034 Reset mid-EXEC -> next cycle IDLE, all tape cells = 0, core_reset = 1, no pending write committed.
REQ-035 Same-cycle write + start in DONE: write tape[0] = 4 with start -> first core_sym = 4; step_count cleared to 0 on entry to FETCH.
